// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with a start/busy/done handshake.
// WIDTH iterations through one WIDTH-bit adder; signed mode multiplies magnitudes and fixes the sign.
module seq_multiplier #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic               neg_q;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] p_final;

  assign signed_op = SIGNED_EN && is_signed;

  // Negating the most negative value yields 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

  // Multiplier lives in the low half of the accumulator and is consumed as the product shifts in.
  assign addend   = acc_q[0] ? mcand_q : '0;
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_step = {sum, acc_q[WIDTH-1:1]};
  assign p_final  = neg_q ? -acc_step : acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      p       <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
            mcand_q <= a_mag;
            acc_q   <= {{WIDTH{1'b0}}, b_mag};
            cnt_q   <= CntW'(WIDTH - 1);
            neg_q   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q <= acc_step;
          if (cnt_q == '0) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            p       <= p_final;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a signed-enabled and a SIGNED_EN=0 instance share stimulus.
// Expected products come from integer arithmetic; a negedge monitor pops and checks on each done.
module tb_seq_multiplier;

  localparam int unsigned W = 8;

  typedef struct {
    logic [2*W-1:0] p;
    int             cyc;
  } sb_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           is_signed = 1'b0;
  logic [1:0]     busy_w;
  logic [1:0]     done_w;
  logic [2*W-1:0] p_w [2];

  sb_t            sbq [2][$];
  logic [2*W-1:0] last_p [2];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_pass = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .is_signed(is_signed),
    .busy(busy_w[0]), .done(done_w[0]), .p(p_w[0])
  );

  seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .is_signed(is_signed),
    .busy(busy_w[1]), .done(done_w[1]), .p(p_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
    int sx;
    int sy;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    return (2*W)'(sx * sy);
  endfunction

  // Monitor: every done must match the oldest pending op; p must otherwise hold its last value.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (done_w[i]) begin
          if (sbq[i].size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done[%0d]: got done=1, expected no done (t=%0t)", i, $time);
          end else begin
            sb_t e;
            e = sbq[i].pop_front();
            chk($sformatf("product[%0d]", i), 32'(p_w[i]), 32'(e.p));
            chk($sformatf("done_cycle[%0d]", i), cyc, e.cyc);
            chk($sformatf("busy_at_done[%0d]", i), 32'(busy_w[i]), 32'd0);
            last_p[i] = e.p;
          end
        end else begin
          chk($sformatf("p_hold[%0d]", i), 32'(p_w[i]), 32'(last_p[i]));
        end
      end
    end
  end

  // Presents one op once both DUTs are free; done is due W+1 cycles after the start cycle.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is);
    int guard;
    guard = 0;
    @(negedge clk); #1;
    while (busy_w != 2'b00) begin
      guard++;
      if (guard > 100) begin
        n_checks++;
        $display("FAIL issue_timeout: got busy=%b, expected 00 within 100 cycles", busy_w);
        return;
      end
      @(negedge clk); #1;
    end
    a = ia;
    b = ib;
    is_signed = is;
    start = 1'b1;
    sbq[0].push_back('{p: ref_prod(ia, ib, is), cyc: cyc + W + 1});
    sbq[1].push_back('{p: ref_prod(ia, ib, 1'b0), cyc: cyc + W + 1});
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy_w), 32'b11);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq[0].size() != 0 || sbq[1].size() != 0) begin
      guard++;
      if (guard > 50) begin
        n_checks++;
        $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", sbq[0].size(),
                 sbq[1].size());
        sbq[0].delete();
        sbq[1].delete();
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    last_p[0] = '0;
    last_p[1] = '0;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_p", 32'(p_w[i]), 32'd0);
      chk("reset_busy", 32'(busy_w[i]), 32'd0);
      chk("reset_done", 32'(done_w[i]), 32'd0);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    idle(20);

    // Corners
    issue(8'd0, 8'd0, 1'b0);
    issue(8'hFF, 8'hFF, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);
    issue(8'h80, 8'h80, 1'b1);
    issue(8'h80, 8'h7F, 1'b1);
    issue(8'h07, 8'hFD, 1'b1);
    issue(8'hFF, 8'hFF, 1'b0);
    issue(8'h00, 8'h80, 1'b1);
    drain();

    // start during RUN with other operands must be ignored
    issue(8'h12, 8'h34, 1'b0);
    idle(3); #1;
    a = 8'hAA;
    b = 8'h55;
    is_signed = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain();
    idle(12);

    // Back-to-back: second start lands in the DONE cycle
    issue(8'd200, 8'd100, 1'b0);
    issue(8'd3, 8'd5, 1'b0);
    drain();

    // Asynchronous reset in the 4th RUN cycle discards the op
    issue(8'h5A, 8'hC3, 1'b1);
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    sbq[0].delete();
    sbq[1].delete();
    last_p[0] = '0;
    last_p[1] = '0;
    for (int i = 0; i < 2; i++) begin
      chk("midrun_reset_p", 32'(p_w[i]), 32'd0);
      chk("midrun_reset_busy", 32'(busy_w[i]), 32'd0);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    idle(15);
    issue(8'd6, 8'd7, 1'b0);
    drain();

    // Randomised traffic with random gaps
    for (int k = 0; k < 60; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        drain();
        idle($urandom_range(0, 3));
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
